// File: rtl/pwm_burst_seq.sv
// Burst sequencer for the half-bridge dead-time/pulse stage: arms the stage N times per burst.
// Optional watchdog on the stage's end-of-cycle response: define PWM_BURST_WDOG_EN.
module pwm_burst_seq #(
    parameter int _RAM_WIDTH  = 32,
    parameter int _CNT_WIDTH  = 16,
    parameter int _WDOG_LIMIT = 1048576
) (
    input  logic                  io_clk,
    input  logic                  io_rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [_RAM_WIDTH-1:0] cfg_die_period,
    input  logic [_RAM_WIDTH-1:0] cfg_pulse_period,
    input  logic [_CNT_WIDTH-1:0] cfg_cycles,
    input  logic                  start,
    input  logic                  abort,
    output logic                  stg_en,
    output logic [_RAM_WIDTH-1:0] stg_die_period,
    output logic [_RAM_WIDTH-1:0] stg_pulse_period,
    output logic                  stg_dis,
    input  logic                  stg_done,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic                  timeout,
    output logic [_CNT_WIDTH-1:0] cycles_done
);
    typedef enum logic [2:0] {IDLE, ARM, WAIT, FINISH, ABORT} state_t;

    state_t                state_p0;
    state_t                state_nx;
    logic                  rearm_p0;
    logic [_RAM_WIDTH-1:0] sh_die_period;
    logic [_RAM_WIDTH-1:0] sh_pulse_period;
    logic [_CNT_WIDTH-1:0] sh_cycles;
    logic [_CNT_WIDTH-1:0] act_cycles;
    logic [_CNT_WIDTH-1:0] cnt_inc;
    logic                  go;
    logic                  zero_go;
    logic                  count_hit;

    function automatic logic [_CNT_WIDTH-1:0] sat_inc(input logic [_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(_CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

`ifdef PWM_BURST_WDOG_EN
    localparam int WDOG_W = $clog2(_WDOG_LIMIT + 1);
    logic [WDOG_W-1:0] wdog_cnt_p0;
    logic              wdog_fire;

    // A trip is flagged one cycle ahead of ABORT so timeout and aborted land in consecutive cycles.
    assign wdog_fire = (state_p0 == WAIT) && !abort && !stg_done && !rearm_p0 && !timeout &&
                       (wdog_cnt_p0 == WDOG_W'(_WDOG_LIMIT - 1));

    always_ff @(posedge io_clk) begin
        if (io_rst || state_p0 != WAIT) begin
            wdog_cnt_p0 <= '0;
            timeout     <= 1'b0;
        end else begin
            if (wdog_cnt_p0 != WDOG_W'(_WDOG_LIMIT))
                wdog_cnt_p0 <= wdog_cnt_p0 + 1'b1;
            timeout <= wdog_fire;
        end
    end
`else
    assign timeout = (_WDOG_LIMIT < 0);  // constant 0 in this build
`endif

    always_comb begin
        state_nx  = state_p0;
        go        = 1'b0;
        zero_go   = 1'b0;
        count_hit = 1'b0;
        cnt_inc   = sat_inc(cycles_done);
        case (state_p0)
            IDLE: begin
                if (start && !abort) begin
                    if (sh_cycles != '0) begin
                        state_nx = ARM;
                        go       = 1'b1;
                    end else begin
                        zero_go  = 1'b1;
                    end
                end
            end
            ARM:    state_nx = abort ? ABORT : WAIT;
            WAIT: begin
                // A completed non-final cycle parks one clock in WAIT before re-arming.
                if (abort || timeout) begin
                    state_nx = ABORT;
                end else if (rearm_p0) begin
                    state_nx = ARM;
                end else if (stg_done) begin
                    count_hit = 1'b1;
                    if (cnt_inc == act_cycles)
                        state_nx = FINISH;
                end
            end
            FINISH: state_nx = abort ? ABORT : IDLE;
            ABORT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            state_p0         <= IDLE;
            rearm_p0         <= 1'b0;
            cfg_ready        <= 1'b1;
            busy             <= 1'b0;
            stg_en           <= 1'b0;
            stg_dis          <= 1'b0;
            done             <= 1'b0;
            aborted          <= 1'b0;
            cycles_done      <= '0;
            sh_die_period    <= '0;
            sh_pulse_period  <= '0;
            sh_cycles        <= '0;
            act_cycles       <= '0;
            stg_die_period   <= '0;
            stg_pulse_period <= '0;
        end else begin
            state_p0  <= state_nx;
            rearm_p0  <= count_hit && (cnt_inc != act_cycles);
            cfg_ready <= (state_nx == IDLE);
            busy      <= (state_nx != IDLE);
            stg_en    <= (state_nx == ARM);
            stg_dis   <= (state_nx == ABORT);
            aborted   <= (state_nx == ABORT);
            done      <= (state_nx == FINISH) || zero_go;
            if (cfg_valid && cfg_ready) begin
                sh_die_period   <= cfg_die_period;
                sh_pulse_period <= cfg_pulse_period;
                sh_cycles       <= cfg_cycles;
            end
            if (go) begin
                stg_die_period   <= sh_die_period;
                stg_pulse_period <= sh_pulse_period;
                act_cycles       <= sh_cycles;
                cycles_done      <= '0;
            end else if (count_hit) begin
                cycles_done      <= cnt_inc;
            end
        end
    end
endmodule

// File: tb/tb_pwm_burst_seq.sv
// Scoreboard bench for pwm_burst_seq: a 20-cycle stage model answers each enable,
// expected output events are queued at stimulus time and matched as the DUT emits them.
module tb_pwm_burst_seq;
    localparam int RW = 32;
    localparam int CW = 16;
    localparam int WL = 50;
    localparam logic [4:0] EV_EN   = 5'b00001;
    localparam logic [4:0] EV_DONE = 5'b00010;
    localparam logic [4:0] EV_ABT  = 5'b01100;
    localparam logic [4:0] EV_TMO  = 5'b10000;

    logic          io_clk = 1'b0;
    logic          io_rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [RW-1:0] cfg_die_period;
    logic [RW-1:0] cfg_pulse_period;
    logic [CW-1:0] cfg_cycles;
    logic          start;
    logic          abort;
    logic          main_abort;
    logic          stage_abort = 1'b0;
    logic          stg_en;
    logic [RW-1:0] stg_die_period;
    logic [RW-1:0] stg_pulse_period;
    logic          stg_dis;
    logic          stg_done = 1'b0;
    logic          busy;
    logic          done;
    logic          aborted;
    logic          timeout;
    logic [CW-1:0] cycles_done;

    assign abort = main_abort | stage_abort;

    pwm_burst_seq #(._RAM_WIDTH(RW), ._CNT_WIDTH(CW), ._WDOG_LIMIT(WL)) dut (
        .io_clk(io_clk), .io_rst(io_rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_die_period(cfg_die_period), .cfg_pulse_period(cfg_pulse_period),
        .cfg_cycles(cfg_cycles), .start(start), .abort(abort),
        .stg_en(stg_en), .stg_die_period(stg_die_period),
        .stg_pulse_period(stg_pulse_period), .stg_dis(stg_dis),
        .stg_done(stg_done), .busy(busy), .done(done), .aborted(aborted),
        .timeout(timeout), .cycles_done(cycles_done)
    );

    always #5 io_clk = ~io_clk;

    typedef struct {
        logic [4:0] ev;
        int         cyc;
        longint     die;
        longint     pulse;
        longint     cd;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_n = 0;
    int   abort_on = -1;
    bit   stage_on = 1'b1;

    always @(posedge io_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic [4:0] ev, input int c, input longint d, input longint p, input longint cd);
        exp_t e;
        e.ev = ev; e.cyc = c; e.die = d; e.pulse = p; e.cd = cd;
        exp_q.push_back(e);
    endtask

    task automatic cfg_write(input int d, input int p, input int c);
        cfg_valid        = 1'b1;
        cfg_die_period   = RW'(d);
        cfg_pulse_period = RW'(p);
        cfg_cycles       = CW'(c);
        @(negedge io_clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge io_clk);
            #1;
            n++;
        end
        chk(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Stage model: pulse_valid 20 cycles after each enable; optionally raises abort alongside it.
    initial forever begin
        int done_at;
        @(negedge io_clk);
        if (cyc == 0) done_at = -1;
        stg_done = stage_on && (cyc == done_at);
        if (stg_done) done_n++;
        stage_abort = stg_done && (done_n == abort_on);
        if (stg_en) done_at = cyc + 20;
    end

    // Output monitor: every event pulse must match the head of the scoreboard.
    initial forever begin
        logic [4:0] obs;
        exp_t       e;
        @(negedge io_clk);
        obs = {timeout, aborted, stg_dis, done, stg_en};
        if (obs != 5'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", obs, 0);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", obs, e.ev);
                chk("event_cycle", cyc, e.cyc);
                chk("event_cycles_done", cycles_done, e.cd);
                if (e.ev == EV_EN) begin
                    chk("en_die_period", stg_die_period, e.die);
                    chk("en_pulse_period", stg_pulse_period, e.pulse);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL sim_time_limit: got cycle %0d, expected completion", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int s;
        io_rst = 1'b1; cfg_valid = 1'b0; cfg_die_period = '0; cfg_pulse_period = '0;
        cfg_cycles = '0; start = 1'b0; main_abort = 1'b0;
        repeat (3) @(negedge io_clk);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_stg_en", stg_en, 0);
        chk("rst_stg_dis", stg_dis, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycles_done", cycles_done, 0);
        chk("rst_die_period", stg_die_period, 0);
        chk("rst_pulse_period", stg_pulse_period, 0);
        io_rst = 1'b0;
        @(negedge io_clk);

        // zero-cycle burst: shadows are still at reset value
        start = 1'b1; s = cyc;
        push(EV_DONE, s + 1, 0, 0, 0);
        @(negedge io_clk); start = 1'b0;
        chk("zero_busy_t1", busy, 0);
        @(negedge io_clk);
        chk("zero_busy_t2", busy, 0);
        wait_drain("zero_drain", 5);

        // four-cycle burst, config write attempted mid-burst
        cfg_write(3, 5, 4);
        start = 1'b1; s = cyc;
        for (int k = 0; k < 4; k++) push(EV_EN, s + 1 + 22 * k, 3, 5, k);
        push(EV_DONE, s + 88, 0, 0, 4);
        @(negedge io_clk); start = 1'b0;
        repeat (9) @(negedge io_clk);
        chk("busy_cfg_ready", cfg_ready, 0);
        chk("busy_flag", busy, 1);
        cfg_write(9, 7, 1);
        wait_drain("burst4_drain", 150);
        @(negedge io_clk);
        chk("burst4_busy_after", busy, 0);
        chk("burst4_cycles_done", cycles_done, 4);
        chk("burst4_cfg_ready", cfg_ready, 1);

        // abort in the same cycle as the second stage response
        abort_on = done_n + 2;
        start = 1'b1; s = cyc;
        push(EV_EN, s + 1, 3, 5, 0);
        push(EV_EN, s + 23, 3, 5, 1);
        push(EV_ABT, s + 44, 0, 0, 1);
        @(negedge io_clk); start = 1'b0;
        wait_drain("abort_drain", 80);
        @(negedge io_clk);
        chk("abort_cycles_done", cycles_done, 1);
        chk("abort_busy_after", busy, 0);

        // abort alone and abort with start while idle: no activity
        main_abort = 1'b1;
        @(negedge io_clk);
        start = 1'b1;
        @(negedge io_clk);
        start = 1'b0; main_abort = 1'b0;
        repeat (4) @(negedge io_clk);
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_cycles_done", cycles_done, 1);

        // reset during the second WAIT
        start = 1'b1; s = cyc;
        push(EV_EN, s + 1, 3, 5, 0);
        push(EV_EN, s + 23, 3, 5, 1);
        @(negedge io_clk); start = 1'b0;
        while (cyc < s + 30) @(negedge io_clk);
        chk("prerst_cycles_done", cycles_done, 1);
        io_rst = 1'b1;
        @(negedge io_clk);
        io_rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_cycles_done", cycles_done, 0);
        chk("midrst_cfg_ready", cfg_ready, 1);
        chk("midrst_die_period", stg_die_period, 0);
        repeat (20) @(negedge io_clk);
        chk("midrst_events_left", exp_q.size(), 0);

        // single-cycle burst
        cfg_write(11, 13, 1);
        start = 1'b1; s = cyc;
        push(EV_EN, s + 1, 11, 13, 0);
        push(EV_DONE, s + 22, 0, 0, 1);
        @(negedge io_clk); start = 1'b0;
        wait_drain("single_drain", 40);
        @(negedge io_clk);
        chk("single_cycles_done", cycles_done, 1);

        // stage never answers
        cfg_write(2, 4, 3);
        stage_on = 1'b0;
        start = 1'b1; s = cyc;
        push(EV_EN, s + 1, 2, 4, 0);
`ifdef PWM_BURST_WDOG_EN
        push(EV_TMO, s + 52, 0, 0, 0);
        push(EV_ABT, s + 53, 0, 0, 0);
        @(negedge io_clk); start = 1'b0;
        wait_drain("wdog_drain", 80);
`else
        @(negedge io_clk); start = 1'b0;
        while (cyc < s + 70) @(negedge io_clk);
        chk("nowdog_timeout", timeout, 0);
        chk("nowdog_busy", busy, 1);
        main_abort = 1'b1;
        push(EV_ABT, s + 71, 0, 0, 0);
        @(negedge io_clk); main_abort = 1'b0;
        wait_drain("nowdog_drain", 10);
`endif
        @(negedge io_clk);
        chk("stall_busy_after", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
